// File: rtl/alarm_ring_scheduler.sv
// alarm_ring_scheduler: round-robin owner of the shared buzzer/LED ring.
// Optional per-trigger snooze limit: define SNOOZE_LIMIT_EN.
module alarm_ring_scheduler #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300
`ifdef SNOOZE_LIMIT_EN
  ,
  parameter int MAX_SNOOZE  = 3
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic [4:0] trigger,
  input  logic [4:0] alarm_en,
  input  logic       stop,
  input  logic       snooze,
  output logic       buzzer,
  output logic [4:0] ringing,
  output logic [2:0] active_id,
  output logic [4:0] pending,
  output logic [4:0] snoozed,
  output logic       busy
);

  typedef enum logic {IDLE, RING} state_t;

  state_t          state_q, state_d;
  logic [2:0]      id_q, id_d;
  logic [2:0]      ptr_q, ptr_d;
  logic            buz_q, buz_d;
  logic [7:0]      rcnt_q, rcnt_d;
  logic [4:0]      pend_q, pend_d;
  logic [4:0]      snzd_q, snzd_d;
  logic [4:0][8:0] scnt_q, scnt_d;
`ifdef SNOOZE_LIMIT_EN
  logic [4:0][1:0] snum_q, snum_d;
`endif

  logic [4:0] ring_vec;
  logic [4:0] req;
  logic [2:0] sel;
  logic       found;
  logic       exit_ring;

  assign ring_vec  = (state_q == RING) ? (5'b00001 << id_q) : 5'b0;
  assign req       = pend_q & alarm_en;
  assign busy      = (state_q == RING);
  assign ringing   = ring_vec;
  assign active_id = busy ? id_q : 3'd7;
  assign buzzer    = buz_q;
  assign pending   = pend_q;
  assign snoozed   = snzd_q;

  // Round-robin search: first requester after the last granted alarm.
  always_comb begin
    int j;
    j     = 0;
    sel   = 3'd0;
    found = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      j = int'(ptr_q) + k;
      if (j >= 5) j = j - 5;
      if (!found && req[j]) begin
        found = 1'b1;
        sel   = 3'(j);
      end
    end
  end

  // Next-state: request latch, snooze timers and the IDLE/RING sequencer.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    ptr_d     = ptr_q;
    buz_d     = buz_q;
    rcnt_d    = rcnt_q;
    pend_d    = pend_q;
    snzd_d    = snzd_q;
    scnt_d    = scnt_q;
    exit_ring = 1'b0;
`ifdef SNOOZE_LIMIT_EN
    snum_d    = snum_q;
`endif

    for (int i = 0; i < 5; i++) begin
      if (snzd_q[i] && tick_1s) begin
        if (scnt_q[i] == 9'd1) begin
          snzd_d[i] = 1'b0;
          pend_d[i] = 1'b1;
          scnt_d[i] = 9'd0;
        end else begin
          scnt_d[i] = scnt_q[i] - 9'd1;
        end
      end
      if (trigger[i] && alarm_en[i] && !ring_vec[i]) begin
        pend_d[i] = 1'b1;
        snzd_d[i] = 1'b0;
        scnt_d[i] = 9'd0;
`ifdef SNOOZE_LIMIT_EN
        snum_d[i] = 2'd0;
`endif
      end
      if (!alarm_en[i]) begin
        pend_d[i] = 1'b0;
        snzd_d[i] = 1'b0;
        scnt_d[i] = 9'd0;
`ifdef SNOOZE_LIMIT_EN
        snum_d[i] = 2'd0;
`endif
      end
    end

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d     = RING;
          id_d        = sel;
          ptr_d       = sel;
          pend_d[sel] = 1'b0;
          rcnt_d      = 8'(RING_SECS);
          buz_d       = 1'b1;
        end
      end
      RING: begin
        if (!alarm_en[id_q]) begin
          exit_ring = 1'b1;
        end else if (stop) begin
          exit_ring = 1'b1;
`ifdef SNOOZE_LIMIT_EN
          snum_d[id_q] = 2'd0;
`endif
        end else if (snooze) begin
          exit_ring = 1'b1;
`ifdef SNOOZE_LIMIT_EN
          if (snum_q[id_q] == 2'(MAX_SNOOZE)) begin
            snum_d[id_q] = 2'd0;
          end else begin
            snzd_d[id_q] = 1'b1;
            scnt_d[id_q] = 9'(SNOOZE_SECS);
            snum_d[id_q] = snum_q[id_q] + 2'd1;
          end
`else
          snzd_d[id_q] = 1'b1;
          scnt_d[id_q] = 9'(SNOOZE_SECS);
`endif
        end else if (tick_1s) begin
          if (rcnt_q == 8'd1) begin
            exit_ring = 1'b1;
`ifdef SNOOZE_LIMIT_EN
            snum_d[id_q] = 2'd0;
`endif
          end else begin
            rcnt_d = rcnt_q - 8'd1;
            buz_d  = ~buz_q;
          end
        end
        if (exit_ring) begin
          state_d = IDLE;
          buz_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; pointer resets to 4 so alarm 0 is searched first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= 3'd0;
      ptr_q   <= 3'd4;
      buz_q   <= 1'b0;
      rcnt_q  <= 8'd0;
      pend_q  <= 5'd0;
      snzd_q  <= 5'd0;
      scnt_q  <= '0;
`ifdef SNOOZE_LIMIT_EN
      snum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      buz_q   <= buz_d;
      rcnt_q  <= rcnt_d;
      pend_q  <= pend_d;
      snzd_q  <= snzd_d;
      scnt_q  <= scnt_d;
`ifdef SNOOZE_LIMIT_EN
      snum_q  <= snum_d;
`endif
    end
  end

endmodule

// File: tb/tb_alarm_ring_scheduler.sv
// tb_alarm_ring_scheduler: directed scenarios with an expected-value queue.
// Snooze-limit expectations follow SNOOZE_LIMIT_EN.
module tb_alarm_ring_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_1s;
  logic [4:0] trigger;
  logic [4:0] alarm_en;
  logic       stop;
  logic       snooze;
  logic       buzzer;
  logic [4:0] ringing;
  logic [2:0] active_id;
  logic [4:0] pending;
  logic [4:0] snoozed;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] sb[$];

  alarm_ring_scheduler dut (
    .clk(clk),
    .reset(reset),
    .tick_1s(tick_1s),
    .trigger(trigger),
    .alarm_en(alarm_en),
    .stop(stop),
    .snooze(snooze),
    .buzzer(buzzer),
    .ringing(ringing),
    .active_id(active_id),
    .pending(pending),
    .snoozed(snoozed),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: scoreboard empty, observed %0h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    tick_1s = 1'b1;
    cyc(1);
    tick_1s = 1'b0;
    cyc(1);
  endtask

  task automatic trig(input logic [4:0] v);
    trigger = v;
    cyc(1);
    trigger = 5'b0;
  endtask

  initial begin
    reset    = 1'b1;
    tick_1s  = 1'b0;
    trigger  = 5'b0;
    alarm_en = 5'b0;
    stop     = 1'b0;
    snooze   = 1'b0;
    cyc(3);
    push(8'd7);  chk("rst_id", active_id);
    push(8'd0);  chk("rst_ring", ringing);
    push(8'd0);  chk("rst_pend", pending);
    push(8'd0);  chk("rst_buz", buzzer);
    push(8'd0);  chk("rst_busy", busy);
    reset    = 1'b0;
    alarm_en = 5'b11111;
    cyc(1);

    // two simultaneous requests, alarm 0 first, then 2 after a gap
    trig(5'b00101);
    push(8'h05); chk("pend_2req", pending);
    push(8'd0);  chk("pend_busy", busy);
    cyc(1);
    push(8'd0);  chk("grant0_id", active_id);
    push(8'h01); chk("grant0_ring", ringing);
    push(8'd1);  chk("grant0_buz", buzzer);
    push(8'h04); chk("grant0_pend", pending);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    push(8'd7);  chk("gap_id", active_id);
    push(8'd0);  chk("gap_busy", busy);
    cyc(1);
    push(8'd2);  chk("grant2_id", active_id);
    push(8'h04); chk("grant2_ring", ringing);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;

    // ring timeout on alarm 1
    trig(5'b00010);
    cyc(1);
    push(8'd1);  chk("grant1_id", active_id);
    for (int k = 1; k < 60; k++) begin
      tick();
      push(8'(k % 2 == 0)); chk("buz_toggle", buzzer);
      push(8'd1);           chk("ring_busy", busy);
    end
    tick();
    push(8'd0);  chk("tmo_busy", busy);
    push(8'd0);  chk("tmo_buz", buzzer);
    push(8'd7);  chk("tmo_id", active_id);

    // snooze alarm 3 and re-request
    trig(5'b01000);
    cyc(1);
    push(8'd3);  chk("grant3_id", active_id);
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    push(8'h08); chk("snz3_set", snoozed);
    push(8'd0);  chk("snz3_busy", busy);
    repeat (299) tick();
    push(8'h08); chk("snz3_wait", snoozed);
    push(8'h00); chk("snz3_nopend", pending);
    tick_1s = 1'b1;
    cyc(1);
    tick_1s = 1'b0;
    push(8'h08); chk("snz3_repend", pending);
    push(8'h00); chk("snz3_clr", snoozed);
    push(8'd0);  chk("snz3_idle", busy);
    cyc(1);
    push(8'd3);  chk("regrant3", active_id);
    stop   = 1'b1;
    snooze = 1'b1;
    cyc(1);
    stop   = 1'b0;
    snooze = 1'b0;
    push(8'h00); chk("stop_over_snz", snoozed);
    push(8'd0);  chk("stop_snz_busy", busy);

    // alarm 4 disabled while ringing
    trig(5'b10000);
    cyc(1);
    push(8'd4);  chk("grant4_id", active_id);
    alarm_en = 5'b01111;
    cyc(1);
    push(8'd0);  chk("en_drop_busy", busy);
    push(8'd7);  chk("en_drop_id", active_id);
    trig(5'b10000);
    push(8'h00); chk("dis_trig_pend", pending);
    cyc(1);
    push(8'd0);  chk("dis_trig_busy", busy);
    alarm_en = 5'b11111;

    // repeated snoozes on alarm 1
    trig(5'b00010);
    cyc(1);
    push(8'd1);  chk("grant1b_id", active_id);
    for (int s = 1; s <= 3; s++) begin
      snooze = 1'b1;
      cyc(1);
      snooze = 1'b0;
      push(8'h02); chk("snz_n_set", snoozed);
      repeat (300) tick();
      push(8'd1);  chk("snz_n_rering", active_id);
    end
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    push(8'd0);  chk("snz4_busy", busy);
`ifdef SNOOZE_LIMIT_EN
    push(8'h00); chk("snz4_limit", snoozed);
`else
    push(8'h02); chk("snz4_nolimit", snoozed);
`endif

    // asynchronous reset while alarm 2 rings with counter at 30
    trig(5'b00101);
    cyc(1);
    push(8'd2);  chk("grant2b_id", active_id);
    push(8'h01); chk("grant2b_pend", pending);
    repeat (30) tick();
    #3;
    reset = 1'b1;
    #1;
    push(8'h00); chk("arst_ring", ringing);
    push(8'd7);  chk("arst_id", active_id);
    push(8'd0);  chk("arst_buz", buzzer);
    push(8'h00); chk("arst_pend", pending);
    push(8'h00); chk("arst_snz", snoozed);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
